// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// entry patterns and switch bit-field positions.
package led_ctrl_pkg;

    localparam int unsigned LED_W = 8;
    localparam int unsigned SW_W  = 8;

    localparam int unsigned SW_MODE_LO  = 0;
    localparam int unsigned SW_MODE_HI  = 1;
    localparam int unsigned SW_SPEED_LO = 2;
    localparam int unsigned SW_SPEED_HI = 3;
    localparam int unsigned SW_HOLD     = 7;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic [LED_W-1:0] LED_ENTRY_OFF    = 8'h00;
    localparam logic [LED_W-1:0] LED_ENTRY_BLINK  = 8'hFF;
    localparam logic [LED_W-1:0] LED_ENTRY_CHASE  = 8'h01;
    localparam logic [LED_W-1:0] LED_ENTRY_BOUNCE = 8'h01;

    // Pattern loaded on the edge a new mode is accepted
    function automatic logic [LED_W-1:0] entry_pattern(input mode_e m);
        case (m)
            MODE_BLINK:  entry_pattern = LED_ENTRY_BLINK;
            MODE_CHASE:  entry_pattern = LED_ENTRY_CHASE;
            MODE_BOUNCE: entry_pattern = LED_ENTRY_BOUNCE;
            default:     entry_pattern = LED_ENTRY_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Board-side bundle: raw slide switches in, LED drive out.
interface led_pattern_ctrl_if
    import led_ctrl_pkg::*;
();
    logic [SW_W-1:0]  sw;
    logic [LED_W-1:0] led;

    modport master (output sw, input led);
    modport slave  (input sw, output led);
endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick marks the last count of each period.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;

    // Clear beats hold so a mode entry always restarts the period
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (!hold) begin
            pre_cnt_d = (pre_cnt_q == CNT_MAX) ? '0 : pre_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt_q <= '0;
        else        pre_cnt_q <= pre_cnt_d;
    end

    assign tick = !hold && !clr && (pre_cnt_q == CNT_MAX);

endmodule

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer (off/blink/chase/bounce) driven by debounced
// mode switches, a speed select and a hold switch.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_pattern_ctrl_if.slave    bus
);
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]  sw_s_q, sw_s_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]       stp_cnt_q, stp_cnt_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] led_q, led_d;

    mode_e      mode_sw;
    logic [1:0] speed;
    logic       hold;
    logic [2:0] stp_lim;
    logic       mode_chg;
    logic       tick;
    logic       step;

    assign mode_sw = mode_e'(sw_s_q[SW_MODE_HI:SW_MODE_LO]);
    assign speed   = sw_s_q[SW_SPEED_HI:SW_SPEED_LO];
    assign hold    = sw_s_q[SW_HOLD];
    assign stp_lim = 3'((4'b0001 << speed) - 4'b0001);

    // Synchronizer and mode debounce; the counter clears on the edge sw_s moves
    always_comb begin
        sw_meta_d = bus.sw;
        sw_s_d    = sw_meta_q;
        deb_cnt_d = deb_cnt_q;
        if (sw_s_d[SW_MODE_HI:SW_MODE_LO] != sw_s_q[SW_MODE_HI:SW_MODE_LO]) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    assign mode_chg = (deb_cnt_q == DEB_MAX) && (mode_sw != mode_q);

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .clr   (mode_chg),
        .tick  (tick)
    );

    // Step counter; >= lets a lowered speed step on the very next tick
    always_comb begin
        stp_cnt_d = stp_cnt_q;
        step      = 1'b0;
        if (mode_chg) begin
            stp_cnt_d = '0;
        end else if (tick) begin
            if (stp_cnt_q >= stp_lim) begin
                step      = 1'b1;
                stp_cnt_d = '0;
            end else begin
                stp_cnt_d = stp_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            deb_cnt_q <= '0;
            stp_cnt_q <= '0;
            mode_q    <= MODE_OFF;
            dir_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_s_q    <= sw_s_d;
            deb_cnt_q <= deb_cnt_d;
            stp_cnt_q <= stp_cnt_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            led_q     <= led_d;
        end
    end

    // Next state: mode entry wins over a coincident step
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        if (mode_chg) begin
            mode_d = mode_sw;
            dir_d  = 1'b0;
        end else if (step && (mode_q == MODE_BOUNCE)) begin
            if (!dir_q && (led_q == 8'h80))     dir_d = 1'b1;
            else if (dir_q && (led_q == 8'h01)) dir_d = 1'b0;
        end
    end

    always_comb begin
        led_d = led_q;
        if (mode_chg) begin
            led_d = entry_pattern(mode_sw);
        end else if (step) begin
            case (mode_q)
                MODE_BLINK:  led_d = ~led_q;
                MODE_CHASE:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_BOUNCE: begin
                    if (dir_q) led_d = (led_q == 8'h01) ? 8'h02 : (led_q >> 1);
                    else       led_d = (led_q == 8'h80) ? 8'h40 : (led_q << 1);
                end
                default:     led_d = LED_ENTRY_OFF;
            endcase
        end
    end

    assign bus.led = led_q;

endmodule
